// File: rtl/bit_population_counter_pipe_if.sv
// Ready/valid bus for the pipelined population counter.
//
// One interface carries both sides of the block. The upstream side is
// data_i, mode_i, data_val_i and data_ready_o. The downstream side is
// data_o, data_val_o and data_ready_i.
//
// Modports:
//   master - the environment: drives words and downstream ready, reads results.
//   slave  - the counter itself.
//
// Optional build macro BPC_ACCUM_EN adds the packet accumulator signals:
//   data_last_i - marks the last word of a packet.
//   acc_o       - running packet total.
//   acc_val_o   - total is valid; pulses with the last beat of a packet.
interface bit_population_counter_pipe_if #(
  parameter int WIDTH = 16
`ifdef BPC_ACCUM_EN
  , parameter int ACC_WIDTH = 16
`endif
);

  localparam int OUT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] data_i;
  logic             mode_i;
  logic             data_val_i;
  logic             data_ready_o;
  logic [OUT_W-1:0] data_o;
  logic             data_val_o;
  logic             data_ready_i;

`ifdef BPC_ACCUM_EN
  logic                 data_last_i;
  logic [ACC_WIDTH-1:0] acc_o;
  logic                 acc_val_o;

  modport master (
    output data_i, mode_i, data_val_i, data_ready_i, data_last_i,
    input  data_ready_o, data_o, data_val_o, acc_o, acc_val_o
  );

  modport slave (
    input  data_i, mode_i, data_val_i, data_ready_i, data_last_i,
    output data_ready_o, data_o, data_val_o, acc_o, acc_val_o
  );
`else
  modport master (
    output data_i, mode_i, data_val_i, data_ready_i,
    input  data_ready_o, data_o, data_val_o
  );

  modport slave (
    input  data_i, mode_i, data_val_i, data_ready_i,
    output data_ready_o, data_o, data_val_o
  );
`endif

endinterface

// File: rtl/bit_population_counter_pipe.sv
// Pipelined population counter with ready/valid handshakes on both sides.
//
// The block counts the set bits of a WIDTH-bit word. When mode_i is 1 it
// counts the clear bits instead. The pipeline has three parts:
//   - An input register that stores the word, already inverted for zero-count
//     mode.
//   - A register of per-leaf counts. Each leaf covers LEAF_WIDTH bits.
//   - A registered binary adder tree. The leaf count is padded up to a power
//     of two with constant-zero leaves.
// Latency is $clog2(NLEAF) + 2 cycles. Throughput is one word per cycle.
//
// Parameters:
//   WIDTH      - input word width. Must be a multiple of LEAF_WIDTH and >= 2.
//   LEAF_WIDTH - bits counted combinationally per leaf (1..8).
//   ACC_WIDTH  - accumulator width. Exists only with BPC_ACCUM_EN.
//
// Ports:
//   clk_i  - single clock. All logic runs on the rising edge.
//   srst_i - asynchronous, active-high reset. Clears all state.
//   bus    - slave side of bit_population_counter_pipe_if, carrying:
//              data_i, mode_i, data_val_i, data_ready_o (upstream)
//              data_o, data_val_o, data_ready_i (downstream)
//
// Optional build macro BPC_ACCUM_EN adds data_last_i, acc_o and acc_val_o.
// With it, the block keeps a running per-packet sum of the output counts.
module bit_population_counter_pipe #(
  parameter int WIDTH      = 16,
  parameter int LEAF_WIDTH = 4
`ifdef BPC_ACCUM_EN
  , parameter int ACC_WIDTH = 16
`endif
) (
  input logic                         clk_i,
  input logic                         srst_i,
  bit_population_counter_pipe_if.slave bus
);

  localparam int OUT_W     = $clog2(WIDTH) + 1;
  localparam int NLEAF_RAW = WIDTH / LEAF_WIDTH;
  localparam int LEVELS    = $clog2(NLEAF_RAW);
  localparam int NLEAF     = 1 << LEVELS;
  localparam int PAD_W     = NLEAF * LEAF_WIDTH;
  localparam int CNT_W     = $clog2(LEAF_WIDTH) + 1;
  localparam int TREE_W    = CNT_W + LEVELS;

  // One advance enable drives every stage. The pipeline moves unless a valid
  // result is sitting at the output and downstream is not taking it. Bubbles
  // therefore never block new input.
  logic en;
  assign en               = bus.data_ready_i | ~bus.data_val_o;
  assign bus.data_ready_o = en;

  // Valid bits, one per stage:
  //   bit 0          - input register
  //   bit 1          - leaf counts
  //   bits 2 and up  - one per tree level
  logic [LEVELS+1:0] vld_q;

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q <= {vld_q[LEVELS:0], bus.data_val_i};
    end
  end

  // Input stage. Zero-count mode is folded in here so that the rest of the
  // pipeline only ever counts ones.
  logic [WIDTH-1:0] word_q;

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      word_q <= '0;
    end else if (en) begin
      word_q <= bus.mode_i ? ~bus.data_i : bus.data_i;
    end
  end

  // Zero-extending the word up to the padded leaf count lets the padding
  // leaves count constant zeros. Synthesis folds those leaves away.
  logic [PAD_W-1:0] word_pad;
  assign word_pad = PAD_W'(word_q);

  // Leaf counters: a small combinational adder per LEAF_WIDTH slice.
  logic [CNT_W-1:0] leaf_cnt [NLEAF];

  always_comb begin
    for (int i = 0; i < NLEAF; i++) begin
      leaf_cnt[i] = '0;
      for (int b = 0; b < LEAF_WIDTH; b++) begin
        leaf_cnt[i] = leaf_cnt[i] + CNT_W'(word_pad[i*LEAF_WIDTH + b]);
      end
    end
  end

  // Leaf count register.
  logic [CNT_W-1:0] leaf_q [NLEAF];

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      leaf_q <= '{default: '0};
    end else if (en) begin
      leaf_q <= leaf_cnt;
    end
  end

  // Adder tree. Each level halves the number of partial sums and widens them
  // by one bit, so a full word of ones cannot overflow any level.
  for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_lvl
    localparam int W = CNT_W + lv;
    localparam int N = NLEAF >> lv;

    logic [W-2:0] prev  [2*N];
    logic [W-1:0] sum_q [N];

    if (lv == 1) begin : g_from_leaf
      assign prev = leaf_q;
    end else begin : g_from_lvl
      assign prev = g_lvl[lv-1].sum_q;
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
        sum_q <= '{default: '0};
      end else if (en) begin
        for (int j = 0; j < N; j++) begin
          sum_q[j] <= W'(prev[2*j]) + W'(prev[2*j+1]);
        end
      end
    end
  end

  // With a single leaf there is no tree, and the leaf register drives the
  // output directly.
  logic [TREE_W-1:0] tree_out;

  if (LEVELS == 0) begin : g_out_leaf
    assign tree_out = leaf_q[0];
  end else begin : g_out_tree
    assign tree_out = g_lvl[LEVELS].sum_q[0];
  end

  assign bus.data_o     = OUT_W'(tree_out);
  assign bus.data_val_o = vld_q[LEVELS+1];

`ifdef BPC_ACCUM_EN
  // The last-word flag travels in step with the valid bits.
  logic [LEVELS+1:0] last_q;

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      last_q <= '0;
    end else if (en) begin
      last_q <= {last_q[LEVELS:0], bus.data_last_i};
    end
  end

  // acc_sum_q holds the total of the beats already sent in this packet.
  // acc_o adds the beat currently on the output, so it includes that beat.
  // After the last beat of a packet is sent, the sum restarts from zero.
  logic [ACC_WIDTH-1:0] acc_sum_q;
  logic [ACC_WIDTH-1:0] acc_now;

  assign acc_now       = acc_sum_q + (bus.data_val_o ? ACC_WIDTH'(bus.data_o) : '0);
  assign bus.acc_o     = acc_now;
  assign bus.acc_val_o = bus.data_val_o & last_q[LEVELS+1];

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      acc_sum_q <= '0;
    end else if (bus.data_val_o & bus.data_ready_i) begin
      acc_sum_q <= last_q[LEVELS+1] ? '0 : acc_now;
    end
  end
`endif

endmodule

// File: doc/bit_population_counter_pipe.md
# bit_population_counter_pipe

Parametrised, pipelined population counter with a ready/valid handshake on both sides. It counts the set bits, or optionally the clear bits, of a WIDTH-bit word using registered leaf counters followed by a registered adder tree. It accepts one word per clock at full throughput and holds its results under downstream backpressure. It is the drop-in successor to the fixed 16-bit counter and its I/O-register wrapper for wide datapaths, e.g. 64/128-bit parity/weight checks.

## Interface
- WIDTH, 16: input word width; must be a multiple of LEAF_WIDTH and ≥ 2.
- LEAF_WIDTH, 4: bits summed combinationally per leaf counter; 1..8.
- ACC_WIDTH, 16: running-total width; used only with BPC_ACCUM_EN.
- clk_i  in  1  single clock; all logic on rising edge.
- srst_i  in  1  reset, asynchronous, active-high; clears all state.
- data_i  in  WIDTH  word to count.
- mode_i  in  1  0 = count ones, 1 = count zeros; sampled with data_i.
- data_val_i  in  1  input word valid.
- data_ready_o  out  1  block can accept a word this cycle.
- data_o  out  $clog2(WIDTH)+1  count result, range 0..WIDTH.
- data_val_o  out  1  data_o valid.
- data_ready_i  in  1  downstream accepts data_o this cycle.
- data_last_i  in  1  (BPC_ACCUM_EN only) marks last word of a packet.
- acc_o  out  ACC_WIDTH  (BPC_ACCUM_EN only) packet running total.
- acc_val_o  out  1  (BPC_ACCUM_EN only) acc_o valid; pulses with the output beat of the last word.

## Operation
- NLEAF = WIDTH/LEAF_WIDTH, padded up to a power of two with zero-count leaves; LEVELS = $clog2(NLEAF).
- Stage 0: register data_i, with bitwise inversion if mode_i = 1, plus the valid bit.
- Stage 1: register per-leaf counts, each $clog2(LEAF_WIDTH)+1 bits wide.
- Stages 2..LEVELS+1: each tree level registers pairwise sums, widening by 1 bit per level. The final level drives data_o.
- When NLEAF = 1, the leaf register is the output register.
- Each stage carries its own valid bit. Bubbles (invalid stages) propagate but are never output.
- Global advance enable: en = data_ready_i | ~data_val_o. All stage registers, data and valid, load only when en = 1.
- data_ready_o = en, combinational. An input transfer occurs when data_val_i & data_ready_o.
- An output transfer occurs when data_val_o & data_ready_i.
- No arithmetic overflow is possible: the widths are sized exactly for a maximum of WIDTH.
- Reset values: data_o = 0, data_val_o = 0, all internal valids = 0, acc_o = 0, acc_val_o = 0.
- data_ready_o is 1 during and after reset, because data_val_o = 0.
- Reset mid-operation discards all in-flight words. No output beat appears for them.
- Backpressure behaviour:
  - While data_val_o = 1 and data_ready_i = 0, every stage holds and data_o is stable.
  - Words presented while stalled are not taken.
  - data_val_i may be dropped or changed by the source while stalled without any effect.

## Timing
- Latency L = LEVELS + 2 cycles from the input transfer edge to data_val_o = 1, with no stall. For defaults, L = 4.
- Throughput is 1 word/cycle when data_ready_i is held at 1.
- A stall adds exactly the stalled cycles to the latency of every in-flight word.
- Order is strictly preserved.
- data_ready_i is combinationally coupled to data_ready_o. A single-level path is acceptable and required.

## Configuration
- Macro: BPC_ACCUM_EN.
- Defined:
  - Adds data_last_i, acc_o and acc_val_o.
  - data_last_i travels with its word through the pipeline.
  - On each output transfer, the accumulator adds data_o to the running sum, wrapping modulo 2^ACC_WIDTH.
  - acc_o always shows the sum including the current beat.
  - acc_val_o = data_val_o & the beat's last flag.
  - The sum clears to 0 after an output transfer with last = 1, so the next beat starts fresh.
  - Reset clears the sum.
- Undefined: those ports and the accumulator logic are absent. All other behaviour is identical.

## Test plan
- Reset, then data_i = 16'hFFFF, mode_i = 0, data_ready_i = 1 → data_o = 16, data_val_o high exactly 4 cycles after the transfer, for one cycle.
- data_i = 16'h0000, mode_i = 1 → data_o = 16. Then data_i = 16'h00F1, mode_i = 1 → data_o = 11.
- Back-to-back stream 16'h0001, 16'h0003, 16'h0007, 16'h8000 at 1/cycle → outputs 1, 2, 3, 1 on consecutive cycles.
- Stall: hold data_ready_i = 0 for 5 cycles while data_o = 2 is valid → data_o stays 2, data_ready_o = 0, no words lost. Release → remaining words emerge in order.
- Assert srst_i asynchronously, mid-cycle, with 3 words in flight → data_val_o drops immediately, no stale beats after release, data_ready_o = 1.
- BPC_ACCUM_EN defined: packet 16'h000F, 16'h00FF (last) → acc_o = 4, then 12, with acc_val_o = 1 on the second beat. The next packet's first beat 16'h0001 → acc_o = 1.
- Parameter sweep: WIDTH = 64 with LEAF_WIDTH = 4, and WIDTH = 12 with LEAF_WIDTH = 4 (padded) → the L formula and random counts match the reference model.
